// File: rtl/qupls_blend_pipe_pkg.sv
// Shared Qupls blend definitions: mode encoding and default geometry.
package qupls_blend_pipe_pkg;

    localparam int QUPLS_CW   = 10;
    localparam int QUPLS_SW   = 32;
    localparam int QUPLS_NPIX = 2;

    typedef enum logic [1:0] {
        BM_BLEND = 2'd0,
        BM_ADDS  = 2'd1,
        BM_SUBS  = 2'd2,
        BM_MUL   = 2'd3
    } blend_mode_e;

endpackage

// File: rtl/qupls_blend_chan.sv
// One colour channel: products/partial sum in stage 1,
// rounding and saturation in stage 2.
module qupls_blend_chan
    import qupls_blend_pipe_pkg::*;
#(
    parameter int CW = QUPLS_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en1,
    input  logic          en2,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] c0,
    input  logic [CW-1:0] c1,
    output logic [CW-1:0] r
);

    localparam int PW = 2*CW+2;
    localparam logic [PW-1:0] MX   = {{(CW+2){1'b0}}, {CW{1'b1}}};
    localparam logic [PW-1:0] HALF = MX - (MX >> 1);

    blend_mode_e   m0;
    blend_mode_e   m1;
    logic [PW-1:0] ax, c0x, c1x, nax;
    logic [PW-1:0] p0, p1, ps;
    logic [PW-1:0] s1;
    logic [PW-1:0] q;
    logic [CW-1:0] rn;

    assign m0  = blend_mode_e'(mode);
    assign ax  = PW'(a);
    assign c0x = PW'(c0);
    assign c1x = PW'(c1);
    assign nax = MX - ax;

    always_comb begin
        p0 = ((m0 == BM_MUL) ? c1x : ax) * c0x;
        p1 = nax * c1x;
        ps = '0;
        unique case (m0)
            BM_BLEND: ps = p0 + p1 + HALF;
            BM_ADDS:  ps = c0x + c1x;
            BM_SUBS:  ps = (c0x >= c1x) ? c0x - c1x : '0;
            BM_MUL:   ps = p0 + HALF;
        endcase
    end

    // BLEND and MUL carry a fixed-point product; the rest are integer.
    always_comb begin
        q  = s1;
        if (m1 == BM_BLEND || m1 == BM_MUL)
            q = s1 >> CW;
        rn = (q > MX) ? {CW{1'b1}} : q[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            m1 <= BM_BLEND;
        end else if (en1) begin
            s1 <= ps;
            m1 <= m0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r <= '0;
        else if (en2)
            r <= rn;
    end

endmodule

// File: rtl/qupls_blend_pipe.sv
// Two-stage per-channel blend/arith pipeline over NPIX packed
// RGB pixels, with valid/ready flow control.
module qupls_blend_pipe
    import qupls_blend_pipe_pkg::*;
#(
    parameter int CW   = QUPLS_CW,
    parameter int SW   = QUPLS_SW,
    parameter int NPIX = QUPLS_NPIX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         mode,
    input  logic [NPIX*SW-1:0] a,
    input  logic [NPIX*SW-1:0] c0,
    input  logic [NPIX*SW-1:0] c1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NPIX*SW-1:0] o,
    output logic               busy
);

    logic v1, v2, adv;

    assign adv       = !v2 || out_ready;
    assign in_ready  = adv;
    assign out_valid = v2;
    assign busy      = v1 || v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
        end
    end

    for (genvar p = 0; p < NPIX; p++) begin : g_pix
        for (genvar ch = 0; ch < 3; ch++) begin : g_chan
            localparam int B = p*SW + ch*CW;
            qupls_blend_chan #(.CW(CW)) u_chan (
                .clk   (clk),
                .rst_n (rst_n),
                .en1   (adv && in_valid),
                .en2   (adv && v1),
                .mode  (mode),
                .a     (a[B +: CW]),
                .c0    (c0[B +: CW]),
                .c1    (c1[B +: CW]),
                .r     (o[B +: CW])
            );
        end
        if (SW > 3*CW) begin : g_pad
            localparam int PB = p*SW + 3*CW;
            logic unused_pad;
            assign unused_pad = ^{a[PB +: SW-3*CW],
                                  c0[PB +: SW-3*CW],
                                  c1[PB +: SW-3*CW]};
            assign o[PB +: SW-3*CW] = '0;
        end
    end

endmodule

// File: tb/tb_qupls_blend_pipe.sv
// Self-checking bench for qupls_blend_pipe with a per-transfer model.
module tb_qupls_blend_pipe;

    localparam int CW = 10;
    localparam int SW = 32;
    localparam int NPIX = 2;
    localparam int W = NPIX*SW;
    localparam int M = 1023;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   mode;
    logic [W-1:0] a, c0, c1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] o;
    logic         busy;

    qupls_blend_pipe #(.CW(CW), .SW(SW), .NPIX(NPIX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .c0        (c0),
        .c1        (c1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int got = 0;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int chan_ref(int md, int av, int x, int y);
        longint t;
        t = 0;
        case (md)
            0: t = (longint'(av)*x + longint'(M-av)*y + 512) >>> 10;
            1: t = x + y;
            2: t = (x > y) ? x - y : 0;
            default: t = (longint'(x)*y + 512) >>> 10;
        endcase
        if (t > M) t = M;
        return int'(t);
    endfunction

    function automatic logic [W-1:0] word_ref(int md, logic [W-1:0] av,
                                              logic [W-1:0] x,
                                              logic [W-1:0] y);
        logic [W-1:0] r;
        r = '0;
        for (int p = 0; p < NPIX; p++)
            for (int ch = 0; ch < 3; ch++) begin
                int b;
                b = p*SW + ch*CW;
                r[b +: CW] = 10'(chan_ref(md, int'(av[b +: CW]),
                                         int'(x[b +: CW]), int'(y[b +: CW])));
            end
        return r;
    endfunction

    function automatic logic [W-1:0] splat(int v);
        logic [W-1:0] r;
        r = '0;
        for (int p = 0; p < NPIX; p++)
            for (int ch = 0; ch < 3; ch++)
                r[p*SW + ch*CW +: CW] = 10'(v);
        return r;
    endfunction

    // Scoreboard: expected words queued at transfer, popped at handshake.
    logic [W-1:0] expq[$];
    logic [W-1:0] held;
    logic         holding = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            holding = 1'b0;
        end else begin
            check("in_ready_rule", 64'(in_ready),
                  64'(!out_valid || out_ready));
            if (holding) check("stall_hold", o, held);
            if (in_valid && in_ready)
                expq.push_back(word_ref(int'(mode), a, c0, c1));
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_out: got %h expected none", o);
                end else begin
                    check("result", o, expq.pop_front());
                    got++;
                end
            end
            holding = out_valid && !out_ready;
            held = o;
        end
    end

    task automatic send(int md, logic [W-1:0] av, logic [W-1:0] x,
                        logic [W-1:0] y);
        logic acc;
        int k;
        k = 0;
        in_valid = 1'b1;
        mode = 2'(md);
        a = av;
        c0 = x;
        c1 = y;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            k++;
            if (k > 50) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: got no accept expected accept");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Single transfer with the 2-edge latency and a literal expectation.
    task automatic one(string nm, int md, logic [W-1:0] av,
                       logic [W-1:0] x, logic [W-1:0] y,
                       logic [W-1:0] exp);
        send(md, av, x, y);
        check({nm, "_lat0"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check({nm, "_lat1"}, 64'(out_valid), 64'd1);
        check(nm, o, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (busy || expq.size() != 0) begin
            @(posedge clk);
            #1;
            k++;
            if (k > 100) begin
                n_chk++;
                n_fail++;
                $display("FAIL drain_timeout: got busy expected idle");
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        mode = 2'd0;
        a = '0;
        c0 = '0;
        c1 = '0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_o", o, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("pin_blend", 64'(chan_ref(0, 512, 1000, 200)), 64'd600);
        check("pin_mul", 64'(chan_ref(3, 1023, 1023, 1023)), 64'd1022);

        one("blend_half", 0, splat(512), splat(1000), splat(200),
            splat(600));
        one("blend_full", 0, splat(1023), splat(1023), splat(0),
            splat(1022));
        one("adds_sat", 1, splat(0), splat(800), splat(500), splat(1023));
        one("subs_floor", 2, splat(0), splat(100), splat(300), splat(0));
        one("mul_max", 3, splat(0), splat(1023), splat(1023), splat(1022));
        one("subs_pos", 2, splat(0), splat(300), splat(100), splat(200));

        one("iso_adds", 1, {32'hC000_0000, 32'hFFFF_FFFF},
            {32'hC000_0000, 32'hFFFF_FFFF},
            {32'hC000_0000, 32'hFFFF_FFFF},
            {32'h0, 32'h3FFF_FFFF});
        one("iso_blend", 0, {32'hC000_0000, 32'hFFFF_FFFF},
            {32'hC000_0000, 32'hFFFF_FFFF},
            {32'hC000_0000, 32'hFFFF_FFFF},
            {32'h0, 2'b00, 10'd1022, 10'd1022, 10'd1022});

        // Eight back-to-back transfers with the consumer stalled mid-way.
        g0 = got;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(i % 4, {$urandom, $urandom}, {$urandom, $urandom},
                         {$urandom, $urandom});
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    out_ready = !(k >= 3 && k <= 6);
                    if (k == 5) begin
                        #1;
                        check("stall_in_ready", 64'(in_ready), 64'd0);
                        check("stall_out_valid", 64'(out_valid), 64'd1);
                    end
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("stall_count", 64'(got - g0), 64'd8);

        // Random stream with random back-pressure and per-transfer modes.
        g0 = got;
        fork
            begin
                for (int i = 0; i < 24; i++)
                    send(int'($urandom_range(3, 0)), {$urandom, $urandom},
                         {$urandom, $urandom}, {$urandom, $urandom});
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    out_ready = ($urandom_range(3, 0) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("rand_count", 64'(got - g0), 64'd24);

        // Asynchronous reset with two results in flight.
        g0 = got;
        out_ready = 1'b0;
        send(1, splat(0), splat(5), splat(6));
        send(2, splat(0), splat(9), splat(3));
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_o", o, 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_idle", 64'(out_valid), 64'd0);
        end
        check("rst_no_out", 64'(got - g0), 64'd0);
        one("post_rst_first", 0, splat(512), splat(1000), splat(200),
            splat(600));

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
